// File: rtl/regfile_tap_pkg.sv
// Shared types and defaults for the register file tap scanner.
package regfile_tap_pkg;

    localparam int NUM_REGS_DEF = 31;
    localparam int XLEN_DEF     = 32;
    localparam int IDX_W        = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_tap_find_first.sv
// Lowest set bit of a vector, plus flags for "any set" and "exactly one set".
// Purely combinational: zero latency, no flow control.
module regfile_tap_find_first #(
    parameter int N  = 31,
    parameter int IW = 5
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] first_idx,
    output logic          any,
    output logic          single
);

    localparam logic [N-1:0] VEC_ONE = {{(N-1){1'b0}}, 1'b1};

    logic found;

    always_comb begin
        first_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i] && !found) begin
                first_idx = IW'(i);
                found     = 1'b1;
            end
        end
        any    = found;
        single = found && ((vec & (vec - VEC_ONE)) == '0);
    end

endmodule

// File: rtl/regfile_tap_scanner.sv
// Streams the masked integer registers out lowest-index first, one beat per cycle.
// First beat registered one cycle after trigger; valid/ready, payload held while stalled.
// Define REGFILE_TAP_SNAPSHOT_EN to stream from a register-file image captured at trigger.
module regfile_tap_scanner
    import regfile_tap_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int XLEN     = XLEN_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REGS*XLEN-1:0] taps,
    input  logic                     trig,
    input  logic [NUM_REGS-1:0]      mask,
    input  logic                     abort,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_data,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic                     overrun
);

    localparam logic [NUM_REGS-1:0] VEC_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  out_valid_q, out_valid_d;
    logic [XLEN-1:0]       out_data_q, out_data_d;
    logic [IDX_W-1:0]      out_index_q, out_index_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  overrun_q, overrun_d;

    logic                     accept;
    logic                     trig_accept;
    logic [NUM_REGS-1:0]      pending_rest;
    logic [NUM_REGS-1:0]      scan_vec;
    logic [IDX_W-1:0]         ff_idx;
    logic                     ff_any;
    logic                     ff_single;
    logic [NUM_REGS*XLEN-1:0] src_flat;
    logic [XLEN-1:0]          beat_word;

    assign accept       = out_valid_q && out_ready;
    assign trig_accept  = (state_q == ST_IDLE) && trig;
    // The beat on the bus is always the lowest pending bit; dropping it leaves the rest.
    assign pending_rest = pending_q & (pending_q - VEC_ONE);
    assign scan_vec     = (state_q == ST_IDLE) ? mask : pending_rest;

    regfile_tap_find_first #(
        .N  (NUM_REGS),
        .IW (IDX_W)
    ) u_find_first (
        .vec       (scan_vec),
        .first_idx (ff_idx),
        .any       (ff_any),
        .single    (ff_single)
    );

`ifdef REGFILE_TAP_SNAPSHOT_EN
    logic [NUM_REGS*XLEN-1:0] snap_q, snap_d;

    always_comb begin
        snap_d = snap_q;
        if (trig_accept) begin
            snap_d = taps;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    // The first beat loads on the trigger edge, before the image is in snap_q.
    assign src_flat = (state_q == ST_IDLE) ? taps : snap_q;
`else
    assign src_flat = taps;
`endif

    assign beat_word = src_flat[int'(ff_idx)*XLEN +: XLEN];

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        overrun_d   = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    overrun_d = 1'b0;
                    pending_d = mask;
                    if (ff_any) begin
                        state_d     = ST_SEND;
                        out_valid_d = 1'b1;
                        out_data_d  = beat_word;
                        out_index_d = ff_idx + IDX_W'(1);
                        out_last_d  = ff_single;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (trig) begin
                    overrun_d = 1'b1;
                end
                if (accept) begin
                    pending_d = pending_rest;
                end
                if (abort) begin
                    state_d     = ST_DONE;
                    pending_d   = '0;
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    aborted_d   = 1'b1;
                end else if (accept) begin
                    if (out_last_q) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        out_data_d  = beat_word;
                        out_index_d = ff_idx + IDX_W'(1);
                        out_last_d  = ff_single;
                    end
                end
            end
            ST_DONE: begin
                if (trig) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_regfile_tap_scanner.sv
// Bench for regfile_tap_scanner: directed scans plus random traffic against a queue-based model.
module tb_regfile_tap_scanner;

    localparam int NR = 31;
    localparam int XL = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR*XL-1:0]  taps;
    logic              trig;
    logic [NR-1:0]     mask;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [XL-1:0]     out_data;
    logic [4:0]        out_index;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              overrun;

    regfile_tap_scanner #(.NUM_REGS(NR), .XLEN(XL)) dut (
        .clock     (clock),
        .reset     (reset),
        .taps      (taps),
        .trig      (trig),
        .mask      (mask),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the scan is a queue of register numbers still owed.
    int          m_phase;          // 0 idle, 1 streaming, 2 finishing
    int          pend[$];
    logic [XL-1:0] m_snap [NR];
    bit          m_valid, m_last, m_busy, m_done, m_aborted, m_overrun, m_rst;
    int          m_idx;
    logic [XL-1:0] m_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XL-1:0] tap_word(input int k);
        return taps[k*XL +: XL];
    endfunction

    function automatic logic [XL-1:0] beat_src(input int reg_no, input bit first);
`ifdef REGFILE_TAP_SNAPSHOT_EN
        if (!first) return m_snap[reg_no-1];
`endif
        return tap_word(reg_no - 1);
    endfunction

    task automatic present(input bit first);
        m_valid = 1'b1;
        m_idx   = pend[0];
        m_last  = (pend.size() == 1);
        m_data  = beat_src(pend[0], first);
    endtask

    task automatic model_step();
        bit acc;
        m_rst = 1'b0;
        if (reset) begin
            m_phase = 0;
            pend.delete();
            m_valid = 0; m_last = 0; m_idx = 0; m_data = '0;
            m_done = 0; m_aborted = 0; m_overrun = 0;
            m_rst = 1'b1;
        end else begin
            acc       = m_valid && out_ready;
            m_done    = 0;
            m_aborted = 0;
            case (m_phase)
                0: if (trig) begin
                    m_overrun = 0;
                    pend.delete();
                    for (int k = 0; k < NR; k++) begin
                        if (mask[k]) pend.push_back(k + 1);
                        m_snap[k] = tap_word(k);
                    end
                    if (pend.size() == 0) begin
                        m_phase = 2;
                        m_done  = 1;
                    end else begin
                        m_phase = 1;
                        present(1'b1);
                    end
                end
                1: begin
                    if (trig) m_overrun = 1;
                    if (acc) void'(pend.pop_front());
                    if (abort) begin
                        pend.delete();
                        m_phase = 2; m_valid = 0; m_done = 1; m_aborted = 1;
                    end else if (acc) begin
                        if (pend.size() == 0) begin
                            m_phase = 2; m_valid = 0; m_done = 1;
                        end else begin
                            present(1'b0);
                        end
                    end
                end
                default: begin
                    if (trig) m_overrun = 1;
                    m_phase = 0;
                end
            endcase
        end
        m_busy = (m_phase != 0);
    endtask

    task automatic compare();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("busy",      64'(busy),      64'(m_busy));
        check("done",      64'(done),      64'(m_done));
        check("aborted",   64'(aborted),   64'(m_aborted));
        check("overrun",   64'(overrun),   64'(m_overrun));
        if (m_valid) begin
            check("out_index", 64'(out_index), 64'(m_idx));
            check("out_data",  64'(out_data),  64'(m_data));
            check("out_last",  64'(out_last),  64'(m_last));
        end
        if (m_rst) begin
            check("rst_data",  64'(out_data),  64'(0));
            check("rst_index", 64'(out_index), 64'(0));
            check("rst_last",  64'(out_last),  64'(0));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic scan(input logic [NR-1:0] m, input int cycles);
        mask = m; trig = 1'b1;
        cycle();
        trig = 1'b0;
        repeat (cycles) cycle();
    endtask

    initial begin
        reset = 1'b1; trig = 1'b0; abort = 1'b0; out_ready = 1'b0; mask = '0;
        for (int k = 0; k < NR; k++) taps[k*XL +: XL] = $urandom;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Full register file with continuous ready.
        out_ready = 1'b1;
        scan(31'h7FFF_FFFF, 34);

        // Sparse mask with a toggling sink.
        mask = 31'h5; trig = 1'b1;
        cycle();
        trig = 1'b0;
        for (int i = 0; i < 8; i++) begin
            out_ready = i[0];
            cycle();
        end

        // Empty mask completes immediately.
        out_ready = 1'b1;
        scan('0, 3);

        // Trigger during a stalled scan sets overrun; the next real trigger clears it.
        out_ready = 1'b0;
        scan(31'hF, 1);
        trig = 1'b1; cycle();
        trig = 1'b0; cycle();
        out_ready = 1'b1;
        repeat (6) cycle();
        scan(31'h1, 3);

        // Abort on the cycle the second beat is accepted.
        scan(31'hFF, 1);
        abort = 1'b1; cycle();
        abort = 1'b0;
        repeat (3) cycle();

        // Tap word changes while the scan is stalled.
        out_ready = 1'b0;
        scan(31'h11, 0);
        taps[4*XL +: XL] = 32'hDEAD_BEEF;
        repeat (3) cycle();
        out_ready = 1'b1;
        repeat (4) cycle();
        out_ready = 1'b0;
        taps[4*XL +: XL] = 32'h1234_5678;
        scan(31'h10, 0);
        taps[4*XL +: XL] = 32'hDEAD_BEEF;
        repeat (2) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();

        // Reset in the middle of a scan.
        scan(31'hFF, 2);
        reset = 1'b1; cycle();
        reset = 1'b0;
        repeat (3) cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            trig      = ($urandom_range(7) == 0);
            case ($urandom_range(3))
                0:       mask = '0;
                1:       mask = '1;
                2:       mask = NR'(1) << $urandom_range(NR - 1);
                default: mask = NR'($urandom);
            endcase
            out_ready = ($urandom_range(3) != 0);
            abort     = ($urandom_range(15) == 0);
            reset     = ($urandom_range(399) == 0);
            if ($urandom_range(2) == 0) taps[$urandom_range(NR - 1)*XL +: XL] = $urandom;
            cycle();
        end
        trig = 1'b0; abort = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (40) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_tap_scanner.md
REGFILE_TAP_SCANNER -- requirements
Module: regfile_tap_scanner

Interface
REQ-001 SHALL have parameter NUM_REGS, default 31, number of tapped integer registers (x1..x31).
REQ-002 SHALL have parameter XLEN, default 32, width of each register word.
REQ-003 SHALL have port clock, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port taps, input, NUM_REGS*XLEN, flat register file tap; word k at bits [k*XLEN +: XLEN] is register x(k+1).
REQ-006 SHALL have port trig, input, 1, single-cycle request to start a scan.
REQ-007 SHALL have port mask, input, NUM_REGS, register select; bit k selects x(k+1); sampled on trigger accept.
REQ-008 SHALL have port abort, input, 1, terminate the scan in progress.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, XLEN), out_index (output, 5, register number 1..31) and out_last (output, 1, final beat of scan).
REQ-010 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), aborted (output, 1, valid with done) and overrun (output, 1, sticky).

Function
REQ-011 SHALL implement states IDLE, SEND, DONE.
REQ-012 IDLE: trig=1 SHALL latch mask into pending register and go to SEND if mask!=0, else go to DONE; trig is accepted only in IDLE.
REQ-013 SEND SHALL drive out_valid=1 with out_index = lowest pending bit +1, out_data = that tap word, out_last=1 when it is the only pending bit.
REQ-014 On out_valid&&out_ready the pending bit SHALL clear; next beat is presented the following cycle, giving one beat per cycle under continuous out_ready.
REQ-015 out_data, out_index, out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 Accepted beat with out_last=1 SHALL move to DONE.
REQ-017 DONE SHALL last exactly one cycle, assert done=1, then return to IDLE.
REQ-018 busy SHALL be 1 in SEND and DONE, 0 in IDLE.
REQ-019 trig in SEND or DONE SHALL be ignored and set overrun=1; overrun clears on the next accepted trig.
REQ-020 abort in SEND: if the current beat is accepted the same cycle it counts as delivered; state SHALL go to DONE with aborted=1 and out_valid=0 the next cycle.
REQ-021 abort in IDLE or DONE SHALL have no effect; aborted=0 on normal completion.
REQ-022 Index arithmetic SHALL be 5-bit unsigned; index 0 (x0) is never emitted.

Reset
REQ-023 reset SHALL force IDLE, pending=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, aborted=0, overrun=0 on the next edge.
REQ-024 reset mid-scan SHALL drop out_valid with no done pulse.

Configuration
REQ-025 With REGFILE_TAP_SNAPSHOT_EN defined, the block SHALL capture all of taps into a NUM_REGS*XLEN snapshot register on trigger accept and stream from it, giving a coherent image.
REQ-026 Without REGFILE_TAP_SNAPSHOT_EN, out_data SHALL be registered from the live taps word when each beat is loaded (on entering SEND and on each accepted non-last beat), not snapshotted at trigger; no snapshot storage.

Structure
REQ-027 Package regfile_tap_pkg SHALL hold the state enum, NUM_REGS/XLEN defaults and index width constant.
REQ-028 Sub-module regfile_tap_find_first SHALL compute lowest set bit index and single-bit flag of the pending vector, combinationally.

Verification
REQ-029 mask=0x7FFFFFFF, out_ready=1 held -> 31 beats, indices 1..31 on consecutive cycles, out_last on index 31, done one cycle later.
REQ-030 mask=0x00000005, out_ready toggling 1/0 -> beats index 1 and 3 only, data stable while stalled, out_last on index 3.
REQ-031 mask=0 with trig -> no out_valid, done=1 exactly one cycle after trig, aborted=0.
REQ-032 trig during scan -> overrun=1, scan unaffected; next accepted trig clears overrun.
REQ-033 abort after 2nd accepted beat of mask=0xFF -> out_valid low next cycle, done=1 with aborted=1.
REQ-034 With REGFILE_TAP_SNAPSHOT_EN, change taps word x5 to 0xDEADBEEF after trig of mask=0x10 with out_ready=0 -> beat x5 carries pre-trigger value; without macro, beat x5 carries the value present when the beat is loaded into SEND.
